// File: rtl/mux_pkg.sv
// Shared constants and types for the round-robin stream multiplexer.
package mux_pkg;

  // Values carried on the mode input.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Occupancy of the single-word output register.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage : mux_pkg

// File: rtl/rr_arbiter.sv
// Round-robin priority search: the first requester after the previous winner,
// wrapping modulo N_CH. The output is zero when nobody requests.
module rr_arbiter #(
  parameter  int N_CH = 7,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SELW-1:0] last,
  output logic [N_CH-1:0] grant,
  output logic [SELW-1:0] grant_idx
);

  // Visit channels last+1 .. last+N_CH (mod N_CH); the previous winner is checked last.
  always_comb begin
    logic found;
    int   c;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      c = int'(last) + i;
      if (c >= N_CH) c = c - N_CH;
      if (!found && req[c]) begin
        found     = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = SELW'(c);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/stream_mux_rr.sv
// N_CH-to-1 stream multiplexer with a fixed-select or round-robin grant and a
// single registered output word. A held word can drain and be replaced in
// the same cycle, so throughput is one word per cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | no word held, out_valid=0, any granted channel is accepted
//   ST_FULL  | word held on out_data/out_ch, replaced only while out_ready=1
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter  int N_CH  = 7,
  parameter  int WIDTH = 8,
  localparam int SELW  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SELW-1:0]        sel,
  input  logic [N_CH*WIDTH-1:0]  in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SELW-1:0]        out_ch
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic [SELW-1:0]  last_q, last_d;

  logic [N_CH-1:0]  fix_grant;
  logic [N_CH-1:0]  rr_grant;
  logic [SELW-1:0]  rr_idx;
  logic [N_CH-1:0]  grant;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             can_accept;
  logic             xfer;

  rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
    .req       (in_valid),
    .last      (last_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // Fixed-select grant; comparing against every legal index means an
  // out-of-range sel matches nothing and never grants.
  always_comb begin
    fix_grant = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SELW'(k)) fix_grant[k] = in_valid[k];
    end
  end

  // Pick the grant source by mode and gate it into in_ready; data never feeds in_ready.
  always_comb begin
    grant      = (mode == MODE_RR) ? rr_grant : fix_grant;
    grant_idx  = (mode == MODE_RR) ? rr_idx   : sel;
    can_accept = (state_q == ST_EMPTY) || out_ready;
    in_ready   = (rst_n && can_accept) ? grant : '0;
    xfer       = |in_ready;
    grant_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant[k]) grant_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Next state of the output register: load on a transfer, drain on accept, else hold.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    last_d  = last_q;
    if (xfer) begin
      state_d = ST_FULL;
      data_d  = grant_data;
      ch_d    = grant_idx;
      last_d  = grant_idx;
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Output register; reset discards any held word and makes channel 0 the first RR winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      last_q  <= SELW'(N_CH - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule : stream_mux_rr

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter N_CH, default 7: number of input channels, legal range 2..16.
REQ-002 Parameter WIDTH, default 8: data width per channel, legal range >= 1.
REQ-003 Derived localparam SELW = clog2(N_CH): width of the select and channel-ID fields.
REQ-004 Clocking SHALL be one clock with an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 mode  in  1  0 = fixed select, 1 = round-robin.
REQ-008 sel  in  SELW  channel index used in fixed mode.
REQ-009 in_data  in  N_CH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 in_valid  in  N_CH  per-channel valid.
REQ-011 in_ready  out  N_CH  per-channel ready, combinational, one-hot or zero.
REQ-012 out_data  out  WIDTH  registered output data.
REQ-013 out_valid  out  1  output word held.
REQ-014 out_ready  in  1  downstream accept.
REQ-015 out_ch  out  SELW  source channel of out_data.

Function
REQ-016 Block SHALL hold one output word, with state EMPTY (out_valid=0) or FULL (out_valid=1).
REQ-017 can_accept = !out_valid | out_ready.
REQ-018 Transfer on channel k occurs when in_valid[k] & in_ready[k] at a rising edge.
REQ-019 Fixed mode: grant = sel if sel < N_CH and in_valid[sel]; otherwise no grant.
REQ-020 Fixed mode: sel >= N_CH SHALL never grant.
REQ-021 Round-robin mode: grant = first k with in_valid[k], searching from (last+1) mod N_CH upward with wrap to 0.
REQ-022 Round-robin mode: if no channel is valid, there is no grant.
REQ-023 in_ready[k] = (k == grant) & can_accept; all other bits are 0.
REQ-024 in_ready SHALL NOT depend on in_data.
REQ-025 On a transfer, at the next edge: out_data <= channel data, out_ch <= k, out_valid <= 1, last <= k; latency is exactly 1 cycle.
REQ-026 last updates on every transfer in either mode; mode changes take effect on the next grant evaluation without a flush.
REQ-027 FULL with out_ready=1 and a grant: drain and refill occur in the same cycle; out_valid stays 1 and no bubble is inserted.
REQ-028 FULL with out_ready=1 and no grant: out_valid <= 0 at the next edge.
REQ-029 FULL with out_ready=0: out_data and out_ch SHALL be held stable and in_ready SHALL be all 0.
REQ-030 Sustained throughput SHALL be one word per cycle while out_ready=1.

Reset
REQ-031 rst_n low SHALL asynchronously force out_valid=0, out_data=0, out_ch=0, and last=N_CH-1 (channel 0 wins first in round-robin).
REQ-032 A word held at reset assertion is discarded.
REQ-033 in_ready SHALL be 0 while rst_n is low.
REQ-034 Reset release is synchronous to clk; the first transfer can occur on the first edge after release.

Structure
REQ-035 The mode encoding constants (MODE_FIXED=0, MODE_RR=1) SHALL live in shared package mux_pkg.
REQ-036 The round-robin priority search SHALL be a sub-module rr_arbiter (parameter N_CH; inputs req, last; output one-hot grant and grant index).
REQ-037 The output register and handshake logic SHALL stay in stream_mux_rr.

Verification (N_CH=7, WIDTH=8)
REQ-038 Fixed-select scenario: mode=0, sel=3, in_valid=7'h7F, data_k = 8'h10+k, out_ready=1 -> out_data=8'h13 and out_ch=3 every cycle, in_ready=7'b0001000.
REQ-039 Invalid-select scenario: mode=0, sel=7, all channels valid -> in_ready=0, out_valid stays 0.
REQ-040 Round-robin fairness scenario: mode=1, all channels valid, out_ready=1 for 14 cycles after reset -> out_ch sequence 0,1,...,6,0,...,6 with no gaps.
REQ-041 Round-robin skip scenario: mode=1, in_valid=7'b1000101, with last grant=2 -> next grants are 6, then 0, then 2.
REQ-042 Backpressure scenario: FULL with out_data=8'hA5 and out_ready=0 for 5 cycles -> out_data, out_valid and out_ch stable, in_ready=0; on out_ready=1 with a grant present, the new word appears next cycle with no bubble.
REQ-043 Reset-mid-operation scenario: assert rst_n=0 asynchronously mid-cycle while FULL -> out_valid drops immediately without waiting for a clock edge; after release in mode=1 the first grant is channel 0.
